// File: rtl/clk_bringup_pkg.sv
// Shared state encoding and default timing constants for the clock bring-up sequencer.
package clk_bringup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_MMCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABLE     = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAIL       = 3'd4
  } state_e;

  localparam int DEF_MMCM_RST_CYCLES     = 16;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 200000;
  localparam int DEF_LOCK_STABLE_CYCLES  = 2048;
  localparam int DEF_MAX_RETRIES         = 3;
  localparam int DEF_CNT_W               = 20;

  // Bits needed for a counter that reaches (largest cycle parameter - 1).
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles);
    int m;
    m = rst_cycles;
    if (timeout_cycles > m) m = timeout_cycles;
    if (stable_cycles > m) m = stable_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-stage single-bit synchroniser, both stages clear to 0 on reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/clk_bringup_ctrl.sv
// Clock-path bring-up sequencer: MMCM reset, lock wait, lock qualification, output enable,
// and bounded retry / lock-loss recovery. Runs on the free-running input clock.
module clk_bringup_ctrl
  import clk_bringup_pkg::*;
#(
  parameter int MMCM_RST_CYCLES     = DEF_MMCM_RST_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic       clk_200MHz,
  input  logic       rst,
  input  logic       mmcm_locked,
  input  logic       restart,
  output logic       mmcm_reset,
  output logic       out_en,
  output logic       downstream_rst,
  output logic       clk_ok,
  output logic       fail,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt
);

  localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [7:0]           llc_q, llc_d;
  logic                 lock_s;
  logic                 mmcm_reset_q, out_en_q, downstream_rst_q, clk_ok_q, fail_q;

  sync_2ff u_lock_sync (
    .clk_i (clk_200MHz),
    .rst_i (rst),
    .d_i   (mmcm_locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    llc_d   = llc_q;
    case (state_q)
      ST_RESET_MMCM: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          cnt_d = '0;
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_RESET_MMCM;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end
      ST_STABLE: begin
        // Any dropout restarts qualification without consuming a retry.
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = ST_RESET_MMCM;
          retry_d = '0;
          if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
        end
      end
      ST_FAIL: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_RESET_MMCM;
        cnt_d   = '0;
      end
    endcase
    if (restart) begin
      state_d = ST_RESET_MMCM;
      cnt_d   = '0;
      retry_d = '0;
      llc_d   = llc_q;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as state_q.
  always_ff @(posedge clk_200MHz or posedge rst) begin
    if (rst) begin
      state_q          <= ST_RESET_MMCM;
      cnt_q            <= '0;
      retry_q          <= '0;
      llc_q            <= '0;
      mmcm_reset_q     <= 1'b1;
      out_en_q         <= 1'b0;
      downstream_rst_q <= 1'b1;
      clk_ok_q         <= 1'b0;
      fail_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      retry_q          <= retry_d;
      llc_q            <= llc_d;
      mmcm_reset_q     <= (state_d == ST_RESET_MMCM) || (state_d == ST_FAIL);
      out_en_q         <= (state_d == ST_RUN);
      downstream_rst_q <= (state_d != ST_RUN);
      clk_ok_q         <= (state_d == ST_RUN);
      fail_q           <= (state_d == ST_FAIL);
    end
  end

  assign mmcm_reset     = mmcm_reset_q;
  assign out_en         = out_en_q;
  assign downstream_rst = downstream_rst_q;
  assign clk_ok         = clk_ok_q;
  assign fail           = fail_q;
  assign state_o        = state_q;
  assign lock_loss_cnt  = llc_q;

endmodule

// File: tb/tb_clk_bringup_ctrl.sv
// Bench for clk_bringup_ctrl: phase/countdown reference model checked every cycle,
// plus directed scenarios with hand-computed timing expectations.
module tb_clk_bringup_ctrl;

  localparam int RST_C  = 4;
  localparam int TO_C   = 50;
  localparam int STB_C  = 10;
  localparam int MAXR   = 2;
  localparam int CNT_W  = clk_bringup_pkg::cnt_width(RST_C, TO_C, STB_C);

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mmcm_locked = 1'b0;
  logic       restart = 1'b0;
  logic       mmcm_reset, out_en, downstream_rst, clk_ok, fail;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_err    = 0;
  logic cmp_en = 1'b0;

  clk_bringup_ctrl #(
    .MMCM_RST_CYCLES     (RST_C),
    .LOCK_TIMEOUT_CYCLES (TO_C),
    .LOCK_STABLE_CYCLES  (STB_C),
    .MAX_RETRIES         (MAXR),
    .CNT_W               (CNT_W)
  ) dut (
    .clk_200MHz     (clk),
    .rst            (rst),
    .mmcm_locked    (mmcm_locked),
    .restart        (restart),
    .mmcm_reset     (mmcm_reset),
    .out_en         (out_en),
    .downstream_rst (downstream_rst),
    .clk_ok         (clk_ok),
    .fail           (fail),
    .state_o        (state_o),
    .lock_loss_cnt  (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a phase with a remaining-cycle countdown, a 2-deep lock delay line.
  int   m_phase, m_left, m_tries, m_llc;
  logic [1:0] m_pipe;
  logic m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_RESET; m_left = RST_C; m_tries = 0; m_llc = 0; m_pipe = 2'b00;
    end else begin
      m_seen = m_pipe[1];
      m_pipe = {m_pipe[0], mmcm_locked};
      if (restart) begin
        m_phase = P_RESET; m_left = RST_C; m_tries = 0;
      end else begin
        case (m_phase)
          P_RESET: begin
            m_left--;
            if (m_left == 0) begin m_phase = P_WAIT; m_left = TO_C; end
          end
          P_WAIT: begin
            if (m_seen) begin
              m_phase = P_STABLE; m_left = STB_C;
            end else begin
              m_left--;
              if (m_left == 0) begin
                if (m_tries < MAXR) begin
                  m_tries++; m_phase = P_RESET; m_left = RST_C;
                end else begin
                  m_phase = P_FAIL;
                end
              end
            end
          end
          P_STABLE: begin
            if (!m_seen) begin
              m_phase = P_WAIT; m_left = TO_C;
            end else begin
              m_left--;
              if (m_left == 0) begin m_phase = P_RUN; m_tries = 0; end
            end
          end
          P_RUN: begin
            if (!m_seen) begin
              if (m_llc < 255) m_llc++;
              m_tries = 0; m_phase = P_RESET; m_left = RST_C;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp state_o", state_o, m_phase);
      chk("cmp mmcm_reset", mmcm_reset, (m_phase == P_RESET || m_phase == P_FAIL));
      chk("cmp out_en", out_en, (m_phase == P_RUN));
      chk("cmp downstream_rst", downstream_rst, (m_phase != P_RUN));
      chk("cmp clk_ok", clk_ok, (m_phase == P_RUN));
      chk("cmp fail", fail, (m_phase == P_FAIL));
      chk("cmp lock_loss_cnt", lock_loss_cnt, m_llc);
    end
  end

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic pulse_restart();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int i = 0;
    while (state_o !== s && i < 300) begin @(negedge clk); i++; end
    chk(name, state_o, s);
  endtask

  task automatic wait_out_en(input logic v, input string name);
    int i = 0;
    while (out_en !== v && i < 300) begin @(negedge clk); i++; end
    chk(name, out_en, v);
  endtask

  // Counts edges after the one that samples the lock change until out_en reaches v.
  task automatic edge_latency(input logic v, input int exp, input string name,
                              output logic saw_wait);
    int n = 0;
    saw_wait = 1'b0;
    @(posedge clk); #1;
    while (out_en !== v && n < 100) begin
      @(posedge clk); #1; n++;
      if (state_o === 3'd1) saw_wait = 1'b1;
    end
    chk(name, n, exp);
  endtask

  task automatic count_mmcm_high(input string name);
    int n = 0;
    while (mmcm_reset === 1'b1 && n < 100) begin n++; @(negedge clk); end
    chk(name, n, RST_C);
  endtask

  // Samples once per cycle until fail; expects pulse/wait runs of 4,50,4,50,4,50.
  task automatic check_timeout_runs(input string name);
    int runs[$];
    int len = 0;
    logic prev = mmcm_reset;
    for (int i = 0; i < 400 && fail !== 1'b1; i++) begin
      if (mmcm_reset !== prev) begin runs.push_back(len); len = 0; prev = mmcm_reset; end
      len++;
      @(negedge clk);
    end
    chk({name, " reached fail"}, fail, 1);
    chk({name, " run count"}, runs.size(), 5);
    for (int i = 0; i < runs.size() && i < 5; i++)
      chk({name, " run length"}, runs[i], (i % 2 == 0) ? RST_C : TO_C);
    chk({name, " final wait length"}, len, TO_C);
    chk({name, " state_o"}, state_o, 4);
    chk({name, " mmcm_reset"}, mmcm_reset, 1);
  endtask

  initial begin
    logic sw;
    // 1. Nominal bring-up
    do_reset();
    cmp_en = 1'b1;
    count_mmcm_high("t1 mmcm_reset width");
    repeat (16) @(negedge clk);
    mmcm_locked = 1'b1;
    edge_latency(1'b1, 12, "t1 lock-to-out_en", sw);
    chk("t1 downstream_rst", downstream_rst, 0);
    chk("t1 clk_ok", clk_ok, 1);
    chk("t1 model phase", m_phase, P_RUN);

    // 2. One-cycle lock glitch in STABLE
    do_reset();
    wait_state(3'd2, "t2 reach stable");
    repeat (5) @(negedge clk);
    mmcm_locked = 1'b0;
    @(negedge clk);
    mmcm_locked = 1'b1;
    edge_latency(1'b1, 12, "t2 relock-to-out_en", sw);
    chk("t2 returned to wait", sw, 1);

    // 3. Timeout with retries, ending in FAIL
    @(negedge clk);
    mmcm_locked = 1'b0;
    do_reset();
    check_timeout_runs("t3");
    chk("t3 model phase", m_phase, P_FAIL);

    // 5a. Restart from FAIL clears the retry budget
    pulse_restart();
    chk("t5a state_o", state_o, 0);
    chk("t5a fail", fail, 0);
    check_timeout_runs("t5a");

    mmcm_locked = 1'b1;
    pulse_restart();
    wait_out_en(1'b1, "t4 reach run");

    // 4. Lock loss in RUN
    @(negedge clk);
    mmcm_locked = 1'b0;
    edge_latency(1'b0, 2, "t4 loss-to-out_en", sw);
    chk("t4 downstream_rst", downstream_rst, 1);
    chk("t4 clk_ok", clk_ok, 0);
    chk("t4 lock_loss_cnt", lock_loss_cnt, 1);
    @(negedge clk);
    count_mmcm_high("t4 mmcm_reset width");

    // 5b. Restart mid-RUN keeps the loss count
    mmcm_locked = 1'b1;
    wait_out_en(1'b1, "t5b reach run");
    repeat (3) @(negedge clk);
    pulse_restart();
    chk("t5b state_o", state_o, 0);
    chk("t5b out_en", out_en, 0);
    chk("t5b downstream_rst", downstream_rst, 1);
    chk("t5b lock_loss_cnt", lock_loss_cnt, 1);

    // 4b. Saturation after 300 total loss events
    for (int i = 0; i < 299; i++) begin
      mmcm_locked = 1'b1;
      wait_out_en(1'b1, "t4b relock");
      @(negedge clk);
      mmcm_locked = 1'b0;
      wait_out_en(1'b0, "t4b loss");
    end
    chk("t4b lock_loss_cnt sat", lock_loss_cnt, 255);

    // 6. Asynchronous reset between edges while in STABLE
    @(negedge clk);
    mmcm_locked = 1'b1;
    pulse_restart();
    wait_state(3'd2, "t6 reach stable");
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("t6 state_o", state_o, 0);
    chk("t6 mmcm_reset", mmcm_reset, 1);
    chk("t6 out_en", out_en, 0);
    chk("t6 downstream_rst", downstream_rst, 1);
    chk("t6 clk_ok", clk_ok, 0);
    chk("t6 fail", fail, 0);
    chk("t6 lock_loss_cnt", lock_loss_cnt, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
